// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer
//   Steps an active-LED index across NUM_LEDS outputs at STEP_HZ and drives
//   the LEDs in one of four modes: rotate, ping-pong, PWM breathe, hold.
// Ports
//   clock_12mhz : single clock, rising edge
//   reset       : synchronous, active-high
//   enable      : run (1) / pause (0); pause blanks the LEDs, keeps state
//   mode        : 00 ROTATE, 01 PINGPONG, 10 BREATHE, 11 HOLD
//   led         : registered LED drive, 1 = on
//   step_pulse  : registered one-cycle pulse per step
//   active_idx  : current index register
module rgb_led_sequencer #(
  parameter  int CLK_HZ     = 12_000_000,
  parameter  int STEP_HZ    = 1,
  parameter  int NUM_LEDS   = 3,
  parameter  int PWM_BITS   = 8,
  localparam int STEP_TICKS = CLK_HZ / STEP_HZ,
  localparam int TICK_W     = $clog2(STEP_TICKS),
  localparam int IDX_W      = $clog2(NUM_LEDS)
) (
  input  logic                clock_12mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse,
  output logic [IDX_W-1:0]    active_idx
);

  localparam logic [1:0] M_ROTATE   = 2'b00;
  localparam logic [1:0] M_PINGPONG = 2'b01;
  localparam logic [1:0] M_BREATHE  = 2'b10;
  localparam logic [1:0] M_HOLD     = 2'b11;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

  logic [TICK_W-1:0]   tick;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                dir, dir_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic                duty_dir;
  logic [1:0]          mode_q;
  logic                mode_chg, step;
  logic [NUM_LEDS-1:0] led_nxt;

  // A mode change restarts the timer, so it can never coincide with a step.
  assign mode_chg = (mode != mode_q);
  assign step     = enable && (mode != M_HOLD) && !mode_chg && (tick == TICK_LAST);

  assign active_idx = idx;

  // Index / direction next-state. ROTATE and BREATHE wrap, PINGPONG bounces.
  always_comb begin
    idx_nxt = idx;
    dir_nxt = dir;
    if (step) begin
      if (mode == M_PINGPONG) begin
        if (!dir) begin
          if (idx == IDX_LAST) begin
            dir_nxt = 1'b1;
            idx_nxt = idx - 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          if (idx == '0) begin
            dir_nxt = 1'b0;
            idx_nxt = idx + 1'b1;
          end else begin
            idx_nxt = idx - 1'b1;
          end
        end
      end else begin
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Per-LED decode: only the active lane may light; in BREATHE it is gated
  // by the PWM compare.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    assign led_nxt[i] = enable && (idx == IDX_W'(i)) &&
                        ((mode != M_BREATHE) || (pwm_cnt < duty));
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      tick       <= '0;
      idx        <= '0;
      dir        <= 1'b0;
      pwm_cnt    <= '0;
      duty       <= '0;
      duty_dir   <= 1'b0;
      mode_q     <= M_ROTATE;
      step_pulse <= 1'b0;
      led        <= '0;
    end else begin
      mode_q     <= mode;
      idx        <= idx_nxt;
      dir        <= dir_nxt;
      step_pulse <= step;
      led        <= led_nxt;

      if (mode_chg || (mode == M_HOLD))
        tick <= '0;
      else if (enable)
        tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;

      if (mode_chg) begin
        pwm_cnt  <= '0;
        duty     <= '0;
        duty_dir <= 1'b0;
      end else if (enable && (mode == M_BREATHE)) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (step) begin
          duty     <= '0;
          duty_dir <= 1'b0;
        end else if (pwm_cnt == PWM_MAX) begin
          // Triangle ramp: turn around at either end instead of wrapping.
          if (!duty_dir) begin
            if (duty == PWM_MAX) begin
              duty_dir <= 1'b1;
              duty     <= duty - 1'b1;
            end else begin
              duty <= duty + 1'b1;
            end
          end else begin
            if (duty == '0) begin
              duty_dir <= 1'b0;
              duty     <= duty + 1'b1;
            end else begin
              duty <= duty - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/rgb_led_sequencer.md
# rgb_led_sequencer

Parametrised LED sequencer for the iCE40 board LEDs. It steps an active-LED index across `NUM_LEDS` outputs at a programmable rate and supports four modes: rotate, ping-pong, PWM breathe and hold. It is the generalised replacement for the fixed two-colour 1 Hz blinker. It sits directly between the board clock and the LED pins, and exports a step pulse and the current index for other logic.

## Interface
- `CLK_HZ`, 12_000_000, input clock frequency in Hz.
- `STEP_HZ`, 1, step rate in Hz; `STEP_TICKS = CLK_HZ / STEP_HZ` (integer division, must be ≥ 2).
- `NUM_LEDS`, 3, LED count, legal range 2..8; `IDX_W = $clog2(NUM_LEDS)`.
- `PWM_BITS`, 8, PWM resolution for breathe mode, legal range 2..10.
- `clock_12mhz` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: run/pause.
- `mode` input 2: 00 ROTATE, 01 PINGPONG, 10 BREATHE, 11 HOLD.
- `led` output `NUM_LEDS`: registered LED drive, 1 = on.
- `step_pulse` output 1: registered one-cycle pulse on each step.
- `active_idx` output `IDX_W`: current index (registered state).

## Operation
- **State registers**
  - `tick`: counter of width `$clog2(STEP_TICKS)`.
  - `idx`: width `IDX_W`.
  - `dir`: 0 = up.
  - `pwm_cnt`: `PWM_BITS` wide.
  - `duty`: `PWM_BITS` wide.
  - `duty_dir`: 0 = up.
  - `mode_q`: last sampled mode.
- **Step timer**
  - When `enable` = 1 and mode ≠ HOLD, `tick` counts 0..`STEP_TICKS`-1 and wraps to 0.
  - The step event is `tick == STEP_TICKS-1` with the same qualification. It yields exactly one step per `STEP_TICKS` clocks; there is no off-by-one.
  - When `enable` = 0, `tick` holds its value and no step occurs.
- **ROTATE**: on a step, `idx` = `idx+1`, wrapping from `NUM_LEDS-1` to 0.
- **PINGPONG**
  - On a step with `dir` = 0: if `idx == NUM_LEDS-1`, set `dir` = 1 and `idx` = `idx-1`; otherwise `idx+1`.
  - Mirror behaviour at 0 for `dir` = 1.
  - Sequence for `NUM_LEDS` = 3: 0,1,2,1,0,1,2…
- **BREATHE**
  - `idx` advances as in ROTATE.
  - `pwm_cnt` free-runs while enabled.
  - On each `pwm_cnt` wrap (all-ones → 0), `duty` steps by 1 in direction `duty_dir`. At all-ones it reverses to down; at 0 it reverses to up (triangle ramp, never overflows).
  - On a step, `duty` = 0 and `duty_dir` = up.
- **HOLD**: `tick` held at 0, `idx`/`dir` frozen, no steps.
- **LED decode** (registered, computed from current state):
  - ROTATE, PINGPONG, HOLD: `led` = one-hot at `idx`.
  - BREATHE: only bit `idx` may be set, and equals `pwm_cnt < duty`.
  - `enable` = 0: `led` = 0 and all state is preserved; resuming continues from the same `tick`/`idx`.
- **Mode change**
  - Detected as `mode != mode_q`.
  - In that cycle: `tick`, `pwm_cnt` and `duty` clear to 0, `duty_dir` = up. No step fires in that cycle.
  - `idx` and `dir` are retained. Entering PINGPONG at an end index reverses on the next step per the rule above.

## Timing
- Reset values:
  - `led` = 0, `step_pulse` = 0, `active_idx` = 0.
  - `tick` = 0, `dir` = 0, `pwm_cnt` = 0, `duty` = 0, `duty_dir` = 0, `mode_q` = 00.
- Reset mid-operation takes effect on the next edge and overrides `enable`, mode change and step.
- Step latency:
  - The step event at cycle N updates `idx` at the N+1 edge.
  - `step_pulse` is high during cycle N+1.
  - `led` reflects the new `idx` from cycle N+2 (one output register stage).
- After release of reset with `enable` = 1 and mode ROTATE:
  - The first `step_pulse` is high in cycle `STEP_TICKS`, counting the first enabled cycle as 0.
  - Subsequent pulses are spaced exactly `STEP_TICKS` cycles apart.
- `enable` falling in the same cycle as a would-be step: no step (enable is sampled first).
- BREATHE PWM period is 2^`PWM_BITS` clocks. `duty` = 0 gives the LED fully off; all-ones gives it on for 2^`PWM_BITS`-1 of each period.

## Test plan
Parameters for the bench: `CLK_HZ` = 40, `STEP_HZ` = 4, so `STEP_TICKS` = 10; `NUM_LEDS` = 3; `PWM_BITS` = 2.

- **Rotate**: reset 3 cycles, `enable` = 1, mode 00 for 60 cycles → `step_pulse` every 10 cycles; `active_idx` 1,2,0,1,2,0; `led` 010,100,001… lagging `idx` by 1 cycle.
- **Ping-pong**: mode 01 for 80 cycles from reset → `active_idx` sequence 1,2,1,0,1,2,1,0.
- **Pause**: `enable` = 0 for 25 cycles at `tick` = 4 → `led` = 000, no `step_pulse`; after re-enable the next pulse comes 6 cycles later at an unchanged index.
- **Breathe**: mode 10 → over the first 10 cycles `duty` goes 0,1,2… per 4-clock PWM period; `led[idx]` is high exactly `duty` of each 4 clocks; `duty` resets to 0 at the step.
- **Mode switch and hold**: switch 00→11 at `idx` = 2 → `led` stays 100 indefinitely, no pulses; switch 11→01 → the next step goes to `idx` 1.
- **Reset mid-run**: assert `reset` for 1 cycle at `idx` = 2, `tick` = 7 → the next cycle shows `led` = 0, `active_idx` = 0, `step_pulse` = 0; the first step arrives 10 cycles after release.
